micro_sequencer: RTL
====================

# micro_sequencer

Next-state controller for the multicycle CPU's microcoded control unit. It generates the 5-bit state address that indexes the microinstruction ROM. It advances through fetch, decode and per-instruction execution states using the opcode and funct fields held in the instruction register. It also reports instruction completion, counts retired instructions and flags unsupported opcodes.

## Interface
Parameters:
- COUNT_W, 32, width of retired-instruction counter

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  synchronous, active-high; clears all registers
- opcode  input  6  IR[31:26]; stable from state 1 onward
- funct  input  6  IR[5:0]; consulted only when opcode = 000000
- state  output  5  current microstate; drives microinstruction ROM address
- instr_done  output  1  high while state is a terminal state of an instruction
- illegal  output  1  one-cycle pulse after decode of an unsupported opcode/funct
- retired  output  COUNT_W  count of completed (non-illegal) instructions

## Operation
- State register is 5 bits. States 0–14 are defined. States 15–31 are unreachable and must go to 0 on the next edge.
- State meanings:
  - 0 fetch
  - 1 decode
  - 2 memory address / immediate-add compute
  - 3 load read
  - 4 load writeback
  - 5 store write
  - 6 R-type execute
  - 7 R-type writeback
  - 8 beq
  - 9 jump
  - 10 immediate writeback
  - 11 bne
  - 12 ori execute
  - 13 mult (LO write)
  - 14 mflo writeback
- Transitions:
  - 0→1.
  - 1 dispatch on opcode:
    - 100011 (lw), 101011 (sw) or 001000 (addi) → 2.
    - 000000 → funct 011000 (mult) → 13, funct 010010 (mflo) → 14, any other funct → 6.
    - 000100 → 8; 000101 → 11; 000010 → 9; 001101 → 12.
    - Any other opcode → 0, with illegal asserted.
  - 2 dispatch on opcode: lw → 3, sw → 5, addi → 10, anything else → 0.
  - 3→4; 6→7; 12→10.
  - Terminal states go to 0: 4, 5, 7, 8, 9, 10, 11, 13, 14.
- instr_done is a combinational decode of the registered state: high in terminal states only.
- retired increments by 1 on each edge where state is terminal. It wraps modulo 2^COUNT_W with no saturation.
- illegal is registered: high for exactly the cycle in which state = 0 following an illegal decode. It does not touch retired.
- Unknown funct under R-type is not illegal; it executes through 6→7.

## Timing
- Reset values: state = 0, illegal = 0, retired = 0, instr_done = 0.
- Reset has priority over every transition. Reset asserted mid-instruction forces state 0 on the next edge regardless of current state.
- Cycles per instruction, counting from state 0 to the terminal state inclusive:
  - 5: lw
  - 4: sw, R-type, addi, ori
  - 3: beq, bne, j, mult, mflo
  - Illegal: 2 cycles (0, 1), then refetch.
- The state output changes only on the rising edge. ROM lookup downstream is combinational within the same cycle.
- opcode/funct are sampled only in states 1 and 2. Changes in other states have no effect.
- retired updates on the same edge that leaves a terminal state. It is visible the cycle state = 0.
- Back-to-back instructions: the terminal state goes directly to 0 with no idle cycles.

## Test plan
- Reset with opcode = 100011, then release: state sequence is 0,1,2,3,4,0; instr_done high only in state 4; retired = 1 afterward.
- opcode = 000000 with funct 100000, then 011000, then 010010 across three instructions:
  - Sequences are 0,1,6,7 / 0,1,13 / 0,1,14.
  - retired = 3 after 10 cycles.
- opcode = 001101: sequence is 0,1,12,10,0. With opcode = 001000, the sequence is 0,1,2,10,0.
- opcode = 111111 at decode:
  - State returns to 0 after state 1.
  - illegal = 1 for exactly one cycle.
  - retired is unchanged.
  - The next valid opcode proceeds normally.
- Assert reset while in state 3 (lw): state = 0 on the next edge, retired = 0, illegal = 0.
- Preload retired near 2^COUNT_W−1 (COUNT_W = 4, run 16 j instructions, opcode 000010): sequence repeats 0,1,9, and retired wraps from 15 to 0.

Source files
------------

// File: rtl/micro_sequencer.sv
// Microcoded control-unit next-state sequencer: walks fetch/decode/execute
// microstates, flags unsupported opcodes and counts retired instructions.
module micro_sequencer #(
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opcode,
  input  logic [5:0]         funct,
  output logic [4:0]         state,
  output logic               instr_done,
  output logic               illegal,
  output logic [COUNT_W-1:0] retired
);

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEMADR   = 5'd2,
    S_MEMRD    = 5'd3,
    S_MEMWB    = 5'd4,
    S_MEMWR    = 5'd5,
    S_EXECUTE  = 5'd6,
    S_ALUWB    = 5'd7,
    S_BEQ      = 5'd8,
    S_JUMP     = 5'd9,
    S_IMMWB    = 5'd10,
    S_BNE      = 5'd11,
    S_ORIEX    = 5'd12,
    S_MULT     = 5'd13,
    S_MFLO     = 5'd14
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] FN_MULT  = 6'b011000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;

  state_e             state_q, state_d;
  logic               illegal_q, illegal_d;
  logic [COUNT_W-1:0] retired_q, retired_d;
  logic               terminal;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      retired_q <= retired_d;
    end
  end

  // Undefined encodings (15-31) fall into the default arm and refetch.
  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW, OP_ADDI: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct == FN_MULT)      state_d = S_MULT;
            else if (funct == FN_MFLO) state_d = S_MFLO;
            else                       state_d = S_EXECUTE;
          end
          OP_BEQ:  state_d = S_BEQ;
          OP_BNE:  state_d = S_BNE;
          OP_J:    state_d = S_JUMP;
          OP_ORI:  state_d = S_ORIEX;
          default: illegal_d = 1'b1;
        endcase
      end
      S_MEMADR: begin
        case (opcode)
          OP_LW:   state_d = S_MEMRD;
          OP_SW:   state_d = S_MEMWR;
          OP_ADDI: state_d = S_IMMWB;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_EXECUTE: state_d = S_ALUWB;
      S_ORIEX:   state_d = S_IMMWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    case (state_q)
      S_MEMWB, S_MEMWR, S_ALUWB, S_BEQ, S_JUMP,
      S_IMMWB, S_BNE, S_MULT, S_MFLO: terminal = 1'b1;
      default:                        terminal = 1'b0;
    endcase
  end

  always_comb begin
    retired_d = retired_q;
    if (terminal) retired_d = retired_q + COUNT_W'(1);
  end

  assign state      = state_q;
  assign instr_done = terminal;
  assign illegal    = illegal_q;
  assign retired    = retired_q;

endmodule
